dmem_responder: RTL and testbench

Memory-side responder for the core's data port: accepts load/store requests driven by the CPU (chip enable, write enable, address, store data), services them against an internal word-organised RAM after a configurable number of wait states, and returns load data with a one-cycle `ready` pulse. It sits between the core's `data_*` outputs and the backing data store. It is the memory end of the same data-bus protocol the core initiates.

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM that answers core load/store requests after WAIT_CYCLES.
// Optional feature macro DMEM_CLEAR_EN: zero the whole RAM after every reset before serving requests.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  data_be_i,
    output logic [31:0] data_o,
    output logic        data_ready_o,
    output logic        data_err_o,
    output logic        busy_o
);
    localparam int unsigned AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // 33-bit upper bound so a RAM ending at the top of the address space does not wrap to 0.
    localparam logic [32:0] TopAddr = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CntLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
`ifdef DMEM_CLEAR_EN
        StClear,
`endif
        StIdle,
        StWait,
        StResp
    } state_t;

    state_t             state;
    logic               req_we;
    logic [31:0]        req_addr;
    logic [31:0]        req_data;
    logic [3:0]         req_be;
    logic [3:0]         cnt;
    logic [31:0]        mem [DEPTH];
`ifdef DMEM_CLEAR_EN
    logic [AddrW-1:0]   clr_idx;
`endif

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_data;
    logic [3:0]         acc_be;
    logic [AddrW-1:0]   acc_idx;
    logic               acc_err;
    logic               enter_resp;
    logic               mem_we;

    // With zero wait states the access happens on the accept edge, straight from the inputs.
    always_comb begin
        if (state == StIdle) begin
            acc_we   = data_we_i;
            acc_addr = data_addr_i;
            acc_data = data_i;
            acc_be   = data_be_i;
        end else begin
            acc_we   = req_we;
            acc_addr = req_addr;
            acc_data = req_data;
            acc_be   = req_be;
        end
        acc_idx    = AddrW'((acc_addr - BASE_ADDR) >> 2);
        acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                     ({1'b0, acc_addr} >= TopAddr);
        enter_resp = ((state == StIdle) && data_ce_i && (WAIT_CYCLES == 0)) ||
                     ((state == StWait) && (cnt == 4'd0));
        mem_we     = rst && enter_resp && acc_we && !acc_err;
        busy_o     = (state != StIdle);
    end

`ifdef DMEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst && (state == StClear)) begin
            mem[clr_idx] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef DMEM_CLEAR_EN
            state   <= StClear;
            clr_idx <= '0;
`else
            state   <= StIdle;
`endif
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_data     <= '0;
            req_be       <= '0;
            cnt          <= '0;
            data_o       <= '0;
            data_ready_o <= 1'b0;
            data_err_o   <= 1'b0;
        end else begin
            data_ready_o <= 1'b0;
            data_err_o   <= 1'b0;
            if (enter_resp) begin
                data_ready_o <= 1'b1;
                data_err_o   <= acc_err;
                if (acc_err) begin
                    data_o <= '0;
                end else if (!acc_we) begin
                    data_o <= mem[acc_idx];
                end
            end
            unique case (state)
`ifdef DMEM_CLEAR_EN
                StClear: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AddrW'(DEPTH - 1)) state <= StIdle;
                end
`endif
                StIdle: begin
                    if (data_ce_i) begin
                        req_we   <= data_we_i;
                        req_addr <= data_addr_i;
                        req_data <= data_i;
                        req_be   <= data_be_i;
                        cnt      <= CntLoad;
                        state    <= (WAIT_CYCLES == 0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (cnt == 4'd0) state <= StResp;
                    else             cnt   <= cnt - 1'b1;
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (1, 0 and 15 wait states) against a
// word-level reference model; the DMEM_CLEAR_EN build adds the clear-sweep scenario.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam logic [31:0] BaseM = 32'h2000_0000;
    localparam logic [31:0] BaseT = 32'hFFFF_FF00;
`ifdef DMEM_CLEAR_EN
    localparam logic BusyRst = 1'b1;
`else
    localparam logic BusyRst = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [2:0]  ce = '0;
    logic [2:0]  rdy, err, busy;
    logic [31:0] dout [3];

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];
    bit cleared = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .BASE_ADDR(BaseM), .WAIT_CYCLES(1)) u_dut_m (
        .clk(clk), .rst(rst), .data_ce_i(ce[0]), .data_we_i(we), .data_addr_i(addr),
        .data_i(wdata), .data_be_i(be), .data_o(dout[0]), .data_ready_o(rdy[0]),
        .data_err_o(err[0]), .busy_o(busy[0]));
    dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .data_ce_i(ce[1]), .data_we_i(we), .data_addr_i(addr),
        .data_i(wdata), .data_be_i(be), .data_o(dout[1]), .data_ready_o(rdy[1]),
        .data_err_o(err[1]), .busy_o(busy[1]));
    dmem_responder #(.DEPTH(64), .BASE_ADDR(BaseT), .WAIT_CYCLES(15)) u_dut_w15 (
        .clk(clk), .rst(rst), .data_ce_i(ce[2]), .data_we_i(we), .data_addr_i(addr),
        .data_i(wdata), .data_be_i(be), .data_o(dout[2]), .data_ready_o(rdy[2]),
        .data_err_o(err[2]), .busy_o(busy[2]));

    function automatic longint base_of(input int d);
        if (d == 0) return {32'h0, BaseM};
        if (d == 1) return 64'h0;
        return {32'h0, BaseT};
    endfunction

    function automatic longint depth_of(input int d);
        return (d == 0) ? 1024 : 64;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
    endfunction

    function automatic bit exp_err(input int d, input logic [31:0] a);
        longint la = {32'h0, a};
        return (la % 4 != 0) || (la < base_of(d)) || (la >= base_of(d) + 4 * depth_of(d));
    endfunction

    function automatic int key_of(input int d, input logic [31:0] a);
        longint la = {32'h0, a};
        return d * (1 << 20) + int'((la - base_of(d)) / 4);
    endfunction

    function automatic bit model_get(input int key, output logic [31:0] v);
        if (model.exists(key)) begin
            v = model[key];
            return 1'b1;
        end
        v = 'x;
        return cleared;
    endfunction

    // One complete transaction; checks latency, error flag, load data and the one-cycle strobe.
    task automatic do_req(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, output logic [31:0] rd, output bit rerr);
        int k;
        bit seen;
        bit e;
        bit known;
        int key;
        logic [31:0] old;
        logic [31:0] nv;
        rd = '0;
        rerr = 1'b0;
        @(negedge clk);
        we = w; addr = a; wdata = wd; be = b; ce[d] = 1'b1;
        @(posedge clk);
        #1 ce[d] = 1'b0;
        seen = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                seen = 1'b1;
                k = i;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ready_timeout dut%0d addr=%h: no ready within 40 cycles", d, a);
            return;
        end
        checks++;
        if (k != wait_of(d)) begin
            errors++;
            $display("FAIL latency dut%0d: ready after %0d edges, expected %0d", d, k, wait_of(d));
        end
        rd = dout[d];
        rerr = err[d];
        e = exp_err(d, a);
        checks++;
        if (rerr !== e) begin
            errors++;
            $display("FAIL err_flag dut%0d addr=%h: got %b expected %b", d, a, rerr, e);
        end
        if (e) begin
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL err_data dut%0d addr=%h: got %h expected 0", d, a, rd);
            end
        end else begin
            key = key_of(d, a);
            known = model_get(key, old);
            if (!w && known) begin
                checks++;
                if (rd !== old) begin
                    errors++;
                    $display("FAIL load_data dut%0d addr=%h: got %h expected %h", d, a, rd, old);
                end
            end
            if (w && (known || b == 4'hF)) begin
                nv = old;
                for (int i = 0; i < 4; i++) if (b[i]) nv[8*i +: 8] = wd[8*i +: 8];
                model[key] = nv;
            end
        end
        @(negedge clk);
        checks++;
        if (rdy[d] !== 1'b0 || err[d] !== 1'b0 || dout[d] !== rd) begin
            errors++;
            $display("FAIL strobe dut%0d: rdy=%b err=%b data=%h, expected 0 0 %h",
                     d, rdy[d], err[d], dout[d], rd);
        end
    endtask

    task automatic reset_assert(input int cyc);
        @(negedge clk);
        rst = 1'b0;
        ce = '0;
        for (int n = 0; n < 2; n++) begin
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rdy[d] !== 1'b0 || err[d] !== 1'b0 || dout[d] !== 32'h0 ||
                    busy[d] !== BusyRst) begin
                    errors++;
                    $display("FAIL reset_outputs dut%0d: rdy=%b err=%b data=%h busy=%b",
                             d, rdy[d], err[d], dout[d], busy[d]);
                end
            end
            repeat (cyc) @(negedge clk);
        end
    endtask

    task automatic reset_release_wait();
        @(negedge clk);
        rst = 1'b1;
`ifdef DMEM_CLEAR_EN
        model.delete();
        cleared = 1'b1;
`endif
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 3'b000) break;
        end
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b expected 000", busy);
        end
    endtask

    task automatic test_reset();
        reset_assert(3);
        reset_release_wait();
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        bit e;
        do_req(0, 1'b1, BaseM + 32'h10, 32'hDEAD_BEEF, 4'hF, rd, e);
        do_req(0, 1'b0, BaseM + 32'h10, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL store_load: got %h err=%b expected deadbeef err=0", rd, e);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        bit e;
        do_req(0, 1'b1, BaseM + 32'h20, 32'h1122_3344, 4'hF, rd, e);
        do_req(0, 1'b1, BaseM + 32'h20, 32'hAABB_CCDD, 4'b0101, rd, e);
        do_req(0, 1'b0, BaseM + 32'h20, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL byte_lanes: got %h expected 11bb33dd", rd);
        end
        do_req(0, 1'b1, BaseM + 32'h20, 32'hFFFF_FFFF, 4'b0000, rd, e);
        do_req(0, 1'b0, BaseM + 32'h20, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL be_zero_noop: got %h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        bit e;
        do_req(0, 1'b0, BaseM + 32'h2, 32'h0, 4'h0, rd, e);
        do_req(0, 1'b1, BaseM, 32'h1234_5678, 4'hF, rd, e);
        do_req(0, 1'b1, BaseM + 32'h1000, 32'hCAFE_BABE, 4'hF, rd, e);
        do_req(0, 1'b0, BaseM, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL oob_store_word0: got %h expected 12345678", rd);
        end
        do_req(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, e);
        do_req(0, 1'b0, BaseM - 32'h4, 32'h0, 4'h0, rd, e);
        do_req(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, e);
        // This instance ends exactly at the top of the address space.
        do_req(2, 1'b1, 32'hFFFF_FFFC, 32'h0F0E_0D0C, 4'hF, rd, e);
        do_req(2, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'h0F0E_0D0C || e !== 1'b0) begin
            errors++;
            $display("FAIL top_of_space: got %h err=%b expected 0f0e0d0c err=0", rd, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] a;
        bit e;
        int r;
        for (int w = 0; w < 16; w++) do_req(0, 1'b1, BaseM + 32'h100 + w * 4, $urandom, 4'hF, rd, e);
        for (int n = 0; n < 40; n++) begin
            a = BaseM + 32'h100 + 32'($urandom_range(0, 15)) * 4;
            r = $urandom_range(0, 9);
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            if (r == 1) a = a + 32'h1000;
            do_req(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, e);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd;
        bit e;
        logic [31:0] v;
        for (int d = 1; d < 3; d++) begin
            for (int n = 0; n < 3; n++) begin
                v = $urandom;
                do_req(d, 1'b1, 32'(base_of(d)) + 32'(n * 8), v, 4'hF, rd, e);
                do_req(d, 1'b0, 32'(base_of(d)) + 32'(n * 8), 32'h0, 4'h0, rd, e);
            end
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] v;
        bit e;
        int prev;
        int n;
        int p;
        a = 32'(base_of(d)) + 32'h30;
        v = $urandom;
        p = wait_of(d) + 2;
        do_req(d, 1'b1, a, v, 4'hF, rd, e);
        @(negedge clk);
        we = 1'b0; addr = a; ce[d] = 1'b1;
        prev = -1;
        n = 0;
        for (int c = 0; c < 6 * p; c++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                if (prev >= 0) begin
                    checks++;
                    if (c - prev != p) begin
                        errors++;
                        $display("FAIL b2b_spacing dut%0d: %0d cycles expected %0d", d, c - prev, p);
                    end
                end
                checks++;
                if (dout[d] !== v) begin
                    errors++;
                    $display("FAIL b2b_data dut%0d: got %h expected %h", d, dout[d], v);
                end
                prev = c;
                n++;
            end
        end
        ce[d] = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL b2b_count dut%0d: %0d responses expected 6", d, n);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy[d] === 1'b0) break;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bit e;
        do_req(0, 1'b1, BaseM + 32'h40, 32'h0BAD_F00D, 4'hF, rd, e);
        @(negedge clk);
        we = 1'b1; addr = BaseM + 32'h40; wdata = 32'h5A5A_5A5A; be = 4'hF; ce[0] = 1'b1;
        @(posedge clk);
        #1 ce[0] = 1'b0;
        reset_assert(2);
        reset_release_wait();
        do_req(0, 1'b0, BaseM + 32'h40, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== (cleared ? 32'h0 : 32'h0BAD_F00D)) begin
            errors++;
            $display("FAIL reset_mid: got %h (interrupted store must not land)", rd);
        end
    endtask

`ifdef DMEM_CLEAR_EN
    task automatic test_clear();
        logic [31:0] rd;
        bit e;
        int n;
        bit got_rdy;
        reset_assert(2);
        @(negedge clk);
        rst = 1'b1;
        model.delete();
        cleared = 1'b1;
        we = 1'b0; addr = BaseM; ce[0] = 1'b1;
        n = 0;
        got_rdy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (rdy[0] === 1'b1) got_rdy = 1'b1;
            if (busy[0] === 1'b0) break;
        end
        ce[0] = 1'b0;
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL clear_busy_len: busy for %0d cycles expected 1024", n);
        end
        checks++;
        if (got_rdy) begin
            errors++;
            $display("FAIL clear_ignores_req: ready seen=1 expected 0");
        end
        @(negedge clk);
        do_req(0, 1'b0, BaseM, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL clear_word0: got %h expected 0", rd);
        end
        do_req(0, 1'b0, BaseM + 32'hFFC, 32'h0, 4'h0, rd, e);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL clear_word_last: got %h expected 0", rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_random();
        test_latency();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid();
`ifdef DMEM_CLEAR_EN
        test_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
